// File: rtl/sobel_pkg.sv
// Shared types and defaults for the Sobel frame scheduler slice.
package sobel_pkg;

  localparam int unsigned IMG_WIDTH_DEF    = 1280;
  localparam int unsigned IMG_HEIGHT_DEF   = 720;
  localparam int unsigned COORD_W          = 16;
  localparam int unsigned EDGE_ADDR_W      = 20;
  localparam int unsigned DONE_TIMEOUT_DEF = 64;
  localparam int unsigned MAX_WR_BURST_DEF = 8;

  typedef logic [COORD_W-1:0]     coord_t;
  typedef logic [EDGE_ADDR_W-1:0] edge_addr_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    STORE,
    DONE
  } sched_state_t;

endpackage

// File: rtl/sobel_frame_scheduler_if.sv
// Control, engine, loader and edge-map signals of the frame scheduler.
interface sobel_frame_scheduler_if;
  import sobel_pkg::*;

  logic       frame_start;
  logic       frame_abort;
  logic       busy;
  logic       frame_done;
  logic       timeout_err;
  coord_t     x_center;
  coord_t     y_center;
  logic       sob_start;
  logic       sob_done;
  logic       sob_edge;
  logic       wr_req;
  logic       wr_gnt;
  logic       edge_wr_en;
  edge_addr_t edge_wr_addr;
  logic       edge_wr_data;

  modport master (
    output frame_start, frame_abort, sob_done, sob_edge, wr_req,
    input  busy, frame_done, timeout_err, x_center, y_center, sob_start,
           wr_gnt, edge_wr_en, edge_wr_addr, edge_wr_data
  );

  modport slave (
    input  frame_start, frame_abort, sob_done, sob_edge, wr_req,
    output busy, frame_done, timeout_err, x_center, y_center, sob_start,
           wr_gnt, edge_wr_en, edge_wr_addr, edge_wr_data
  );

endinterface

// File: rtl/sobel_raster_counter.sv
// Raster (x,y) walker with a running linear address, so y*W+x needs no multiplier.
module sobel_raster_counter
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int unsigned IMG_HEIGHT = IMG_HEIGHT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_clear,
  input  logic       i_inc,
  output coord_t     o_x,
  output coord_t     o_y,
  output edge_addr_t o_lin_addr,
  output logic       o_last_c
);

  coord_t     r_x;
  coord_t     r_y;
  edge_addr_t r_lin_addr;
  logic       w_x_last;
  logic       w_y_last;

  assign w_x_last = (r_x == COORD_W'(IMG_WIDTH - 1));
  assign w_y_last = (r_y == COORD_W'(IMG_HEIGHT - 1));

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_x        <= '0;
      r_y        <= '0;
      r_lin_addr <= '0;
    end else if (i_inc) begin
      r_lin_addr <= r_lin_addr + EDGE_ADDR_W'(1);
      if (w_x_last) begin
        r_x <= '0;
        r_y <= r_y + COORD_W'(1);
      end else begin
        r_x <= r_x + COORD_W'(1);
      end
    end
  end

  assign o_x        = r_x;
  assign o_y        = r_y;
  assign o_lin_addr = r_lin_addr;
  assign o_last_c   = w_x_last && w_y_last;

endmodule

// File: rtl/sobel_frame_scheduler.sv
// Frame-level scheduler for the Sobel engine: raster scan, edge-map writeback
// and frame-BRAM arbitration between the engine and the camera loader.
module sobel_frame_scheduler
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_WIDTH    = IMG_WIDTH_DEF,
  parameter int unsigned IMG_HEIGHT   = IMG_HEIGHT_DEF,
  parameter int unsigned DONE_TIMEOUT = DONE_TIMEOUT_DEF,
  parameter int unsigned MAX_WR_BURST = MAX_WR_BURST_DEF
) (
  input logic                    clk,
  input logic                    reset,
  sobel_frame_scheduler_if.slave bus
);

  localparam int unsigned TMR_W = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
  localparam int unsigned BST_W = $clog2(MAX_WR_BURST + 1);

  sched_state_t      r_state;
  logic [BST_W-1:0]  r_burst;
  logic [TMR_W-1:0]  r_timer;
  logic              r_edge;
  logic              r_timeout_err;

  sched_state_t      w_state_nxt;
  logic [BST_W-1:0]  w_burst_nxt;
  logic [TMR_W-1:0]  w_timer_nxt;
  logic              w_edge_nxt;
  logic              w_terr_nxt;
  logic              w_clear;
  logic              w_inc;
  logic              w_wr_gnt;
  logic              w_sob_start;
  logic              w_edge_wr_en;
  logic              w_frame_done;
  coord_t            w_x;
  coord_t            w_y;
  edge_addr_t        w_lin_addr;
  logic              w_last;

  sobel_raster_counter #(
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT)
  ) u_raster (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (w_clear),
    .i_inc      (w_inc),
    .o_x        (w_x),
    .o_y        (w_y),
    .o_lin_addr (w_lin_addr),
    .o_last_c   (w_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_burst       <= '0;
      r_timer       <= '0;
      r_edge        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_burst       <= w_burst_nxt;
      r_timer       <= w_timer_nxt;
      r_edge        <= w_edge_nxt;
      r_timeout_err <= w_terr_nxt;
    end
  end

  // Abort takes priority in every busy state; the loader only sees grants in IDLE/ISSUE.
  always_comb begin
    w_state_nxt  = r_state;
    w_burst_nxt  = r_burst;
    w_timer_nxt  = r_timer;
    w_edge_nxt   = r_edge;
    w_terr_nxt   = r_timeout_err;
    w_clear      = 1'b0;
    w_inc        = 1'b0;
    w_wr_gnt     = 1'b0;
    w_sob_start  = 1'b0;
    w_edge_wr_en = 1'b0;
    w_frame_done = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_wr_gnt = bus.wr_req;
        if (bus.frame_start) begin
          w_state_nxt = ISSUE;
          w_clear     = 1'b1;
          w_terr_nxt  = 1'b0;
          w_burst_nxt = '0;
        end
      end
      ISSUE: begin
        if (bus.frame_abort) begin
          w_state_nxt = IDLE;
        end else if (bus.wr_req && (r_burst < BST_W'(MAX_WR_BURST))) begin
          w_wr_gnt    = 1'b1;
          w_burst_nxt = r_burst + BST_W'(1);
        end else begin
          w_sob_start = 1'b1;
          w_burst_nxt = '0;
          w_timer_nxt = '0;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (bus.frame_abort) begin
          w_state_nxt = IDLE;
        end else if (bus.sob_done) begin
          w_edge_nxt  = bus.sob_edge;
          w_state_nxt = STORE;
        end else if (r_timer == TMR_W'(DONE_TIMEOUT - 1)) begin
          w_terr_nxt  = 1'b1;
          w_edge_nxt  = 1'b0;
          w_state_nxt = STORE;
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
        end
      end
      STORE: begin
        if (bus.frame_abort) begin
          w_state_nxt = IDLE;
        end else begin
          w_edge_wr_en = 1'b1;
          if (w_last) begin
            w_state_nxt = DONE;
          end else begin
            w_inc       = 1'b1;
            w_state_nxt = ISSUE;
          end
        end
      end
      DONE: begin
        w_frame_done = !bus.frame_abort;
        w_state_nxt  = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.busy         = (r_state != IDLE);
  assign bus.frame_done   = w_frame_done;
  assign bus.timeout_err  = r_timeout_err;
  assign bus.x_center     = w_x;
  assign bus.y_center     = w_y;
  assign bus.sob_start    = w_sob_start;
  assign bus.wr_gnt       = w_wr_gnt;
  assign bus.edge_wr_en   = w_edge_wr_en;
  assign bus.edge_wr_addr = w_lin_addr;
  assign bus.edge_wr_data = r_edge;

endmodule

// File: tb/tb_sobel_frame_scheduler.sv
// Directed bench for sobel_frame_scheduler on a 4x3 frame with a 10-cycle engine model.
module tb_sobel_frame_scheduler;
  import sobel_pkg::*;

  localparam int W       = 4;
  localparam int H       = 3;
  localparam int NPIX    = W * H;
  localparam int ENG_LAT = 10;
  localparam int TMO     = 64;
  localparam int BURST   = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sobel_frame_scheduler_if bus();

  sobel_frame_scheduler #(
    .IMG_WIDTH    (W),
    .IMG_HEIGHT   (H),
    .DONE_TIMEOUT (TMO),
    .MAX_WR_BURST (BURST)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // engine model state
  int eng_cnt   = 0;
  bit eng_par   = 1'b0;
  int skip_addr = -1;
  bit inj_done  = 1'b0;

  // monitor state
  int cyc       = 0;
  int wr_addr_q[$];
  bit wr_data_q[$];
  int wr_cyc_of[int];
  int start_cyc_of[int];
  int fd_cnt    = 0;
  int gnt_viol  = 0;
  int gnt_run   = 0;
  int runs      = 0;
  int bad_runs  = 0;
  bit pend      = 1'b0;

  function automatic bit exp_edge(int a);
    return bit'(((a % W) ^ (a / W)) & 1);
  endfunction

  // Engine answers 10 cycles after sob_start with parity of (x,y); skip_addr never answers.
  always @(negedge clk) begin
    bit fire;
    int a;
    fire = 1'b0;
    a = int'(bus.y_center) * W + int'(bus.x_center);
    if (reset || !bus.busy) begin
      eng_cnt = 0;
    end else if (bus.sob_start) begin
      eng_cnt = (a == skip_addr) ? 0 : ENG_LAT;
      eng_par = bus.x_center[0] ^ bus.y_center[0];
    end else if (eng_cnt > 0) begin
      eng_cnt = eng_cnt - 1;
      fire = (eng_cnt == 0);
    end
    bus.sob_done = fire | inj_done;
    bus.sob_edge = fire ? eng_par : 1'b1;
  end

  // Passive monitor: write log, frame_done count, grant legality and burst lengths.
  always @(negedge clk) begin
    int a;
    cyc = cyc + 1;
    a = int'(bus.y_center) * W + int'(bus.x_center);
    if (bus.edge_wr_en) begin
      wr_addr_q.push_back(int'(bus.edge_wr_addr));
      wr_data_q.push_back(bus.edge_wr_data);
      wr_cyc_of[int'(bus.edge_wr_addr)] = cyc;
    end
    if (bus.frame_done) fd_cnt = fd_cnt + 1;
    if (bus.wr_gnt && (bus.sob_start || bus.edge_wr_en || pend)) gnt_viol = gnt_viol + 1;
    if (bus.busy && bus.wr_gnt) gnt_run = gnt_run + 1;
    if (bus.sob_start) begin
      runs = runs + 1;
      if (gnt_run != BURST) bad_runs = bad_runs + 1;
      gnt_run = 0;
      pend = 1'b1;
      start_cyc_of[a] = cyc;
    end else if (bus.edge_wr_en || !bus.busy) begin
      pend = 1'b0;
    end
    if (!bus.busy) gnt_run = 0;
  end

  task automatic clear_logs();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_of.delete();
    start_cyc_of.delete();
    fd_cnt = 0;
    gnt_viol = 0;
    runs = 0;
    bad_runs = 0;
  endtask

  // Pulse frame_start and return the cycle index of frame_done (cycle 0 = start cycle).
  task automatic run_frame(output int done_cyc);
    @(posedge clk); #1 bus.frame_start = 1'b1;
    @(posedge clk); #1 bus.frame_start = 1'b0;
    done_cyc = -1;
    for (int n = 1; n < 5000; n++) begin
      @(negedge clk);
      if (bus.frame_done) begin
        done_cyc = n;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [6:0] obs;
    reset = 1'b1;
    bus.frame_start = 1'b0;
    bus.frame_abort = 1'b0;
    bus.wr_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    obs = {bus.busy, bus.frame_done, bus.timeout_err, bus.sob_start,
           bus.wr_gnt, bus.edge_wr_en, bus.edge_wr_data};
    total++;
    if (obs !== 7'b0) begin
      bad++;
      $display("FAIL reset_outputs: got %b want 0000000", obs);
    end
    total++;
    if ({bus.x_center, bus.y_center, bus.edge_wr_addr} !== '0) begin
      bad++;
      $display("FAIL reset_coords: got x=%0d y=%0d addr=%0d want 0", bus.x_center, bus.y_center, bus.edge_wr_addr);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_frame_log(input string tag, input int bad_addr);
    total++;
    if (wr_addr_q.size() !== NPIX) begin
      bad++;
      $display("FAIL %s_write_count: got %0d want %0d", tag, wr_addr_q.size(), NPIX);
    end
    for (int i = 0; i < NPIX && i < wr_addr_q.size(); i++) begin
      bit ed;
      ed = (i == bad_addr) ? 1'b0 : exp_edge(i);
      total++;
      if (wr_addr_q[i] !== i || wr_data_q[i] !== ed) begin
        bad++;
        $display("FAIL %s_write_%0d: got addr=%0d data=%0d want addr=%0d data=%0d", tag, i, wr_addr_q[i], wr_data_q[i], i, ed);
      end
    end
    total++;
    if (fd_cnt !== 1) begin
      bad++;
      $display("FAIL %s_frame_done_count: got %0d want 1", tag, fd_cnt);
    end
  endtask

  task automatic test_full_frame();
    int dc;
    clear_logs();
    run_frame(dc);
    total++;
    if (dc !== 145) begin
      bad++;
      $display("FAIL full_frame_latency: got %0d want 145", dc);
    end
    check_frame_log("full", -1);
    total++;
    if (bus.busy !== 1'b0 || bus.timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL full_end_state: got busy=%b terr=%b want 0 0", bus.busy, bus.timeout_err);
    end
  endtask

  task automatic test_wr_contention();
    int dc;
    clear_logs();
    bus.wr_req = 1'b1;
    #1;
    total++;
    if (bus.wr_gnt !== 1'b1) begin
      bad++;
      $display("FAIL idle_passthrough_gnt: got %b want 1", bus.wr_gnt);
    end
    run_frame(dc);
    bus.wr_req = 1'b0;
    total++;
    if (dc !== 241) begin
      bad++;
      $display("FAIL contention_latency: got %0d want 241", dc);
    end
    total++;
    if (runs !== NPIX || bad_runs !== 0) begin
      bad++;
      $display("FAIL contention_bursts: got starts=%0d bad_bursts=%0d want %0d 0", runs, bad_runs, NPIX);
    end
    total++;
    if (gnt_viol !== 0) begin
      bad++;
      $display("FAIL contention_gnt_legal: got %0d illegal grants want 0", gnt_viol);
    end
    check_frame_log("contention", -1);
  endtask

  task automatic test_timeout();
    int dc;
    clear_logs();
    skip_addr = 5;
    run_frame(dc);
    skip_addr = -1;
    total++;
    if (dc !== 199) begin
      bad++;
      $display("FAIL timeout_latency: got %0d want 199", dc);
    end
    total++;
    if (bus.timeout_err !== 1'b1) begin
      bad++;
      $display("FAIL timeout_err_set: got %b want 1", bus.timeout_err);
    end
    total++;
    if (wr_cyc_of[5] - start_cyc_of[5] !== TMO + 1) begin
      bad++;
      $display("FAIL timeout_wait_len: got %0d want %0d", wr_cyc_of[5] - start_cyc_of[5], TMO + 1);
    end
    check_frame_log("timeout", 5);
  endtask

  task automatic test_abort();
    int dc;
    bit found;
    clear_logs();
    total++;
    if (bus.timeout_err !== 1'b1) begin
      bad++;
      $display("FAIL abort_pre_terr: got %b want 1", bus.timeout_err);
    end
    @(posedge clk); #1 bus.frame_start = 1'b1;
    @(posedge clk); #1 bus.frame_start = 1'b0;
    total++;
    if (bus.timeout_err !== 1'b0 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL start_clears_terr: got terr=%b busy=%b want 0 1", bus.timeout_err, bus.busy);
    end
    found = 1'b0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (bus.sob_start && bus.x_center == 2 && bus.y_center == 1) begin
        found = 1'b1;
        break;
      end
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL abort_find_pixel6: got no start want start at pixel 6");
    end
    @(posedge clk); #1 bus.frame_abort = 1'b1;
    @(posedge clk); #1 bus.frame_abort = 1'b0;
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_busy_drop: got %b want 0", bus.busy);
    end
    repeat (20) @(posedge clk);
    #1;
    total++;
    if (wr_addr_q.size() !== 6 || fd_cnt !== 0) begin
      bad++;
      $display("FAIL abort_no_writes: got writes=%0d done=%0d want 6 0", wr_addr_q.size(), fd_cnt);
    end
    clear_logs();
    run_frame(dc);
    total++;
    if (dc !== 145) begin
      bad++;
      $display("FAIL restart_latency: got %0d want 145", dc);
    end
    check_frame_log("restart", -1);
  endtask

  task automatic test_spurious();
    int dc;
    clear_logs();
    repeat (3) begin
      @(posedge clk); #1 inj_done = 1'b1;
      @(posedge clk); #1 inj_done = 1'b0;
    end
    @(posedge clk); #1;
    total++;
    if (wr_addr_q.size() !== 0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_sob_done_ignored: got writes=%0d busy=%b want 0 0", wr_addr_q.size(), bus.busy);
    end
    bus.wr_req = 1'b1;
    @(posedge clk); #1 bus.frame_start = 1'b1;
    @(posedge clk); #1 bus.frame_start = 1'b0; inj_done = 1'b1;
    @(posedge clk); #1 inj_done = 1'b0;
    @(posedge clk); #1 bus.frame_start = 1'b1;
    @(posedge clk); #1 bus.frame_start = 1'b0;
    dc = -1;
    for (int n = 4; n < 5000; n++) begin
      @(negedge clk);
      if (n == 50) bus.frame_start = 1'b1;
      if (n == 51) bus.frame_start = 1'b0;
      if (bus.frame_done) begin
        dc = n;
        break;
      end
    end
    @(posedge clk); #1;
    bus.wr_req = 1'b0;
    total++;
    if (dc !== 241) begin
      bad++;
      $display("FAIL spurious_latency: got %0d want 241", dc);
    end
    check_frame_log("spurious", -1);
  endtask

  task automatic test_reset_mid_frame();
    logic [6:0] obs;
    skip_addr = 0;
    @(posedge clk); #1 bus.frame_start = 1'b1;
    @(posedge clk); #1 bus.frame_start = 1'b0;
    repeat (70) @(posedge clk);
    #1;
    total++;
    if (bus.timeout_err !== 1'b1 || bus.busy !== 1'b1 || bus.x_center !== 16'd1) begin
      bad++;
      $display("FAIL midframe_pre: got terr=%b busy=%b x=%0d want 1 1 1", bus.timeout_err, bus.busy, bus.x_center);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    obs = {bus.busy, bus.frame_done, bus.timeout_err, bus.sob_start,
           bus.wr_gnt, bus.edge_wr_en, bus.edge_wr_data};
    total++;
    if (obs !== 7'b0) begin
      bad++;
      $display("FAIL midframe_reset_outputs: got %b want 0000000", obs);
    end
    total++;
    if ({bus.x_center, bus.y_center, bus.edge_wr_addr} !== '0) begin
      bad++;
      $display("FAIL midframe_reset_coords: got x=%0d y=%0d addr=%0d want 0", bus.x_center, bus.y_center, bus.edge_wr_addr);
    end
    reset = 1'b0;
    skip_addr = -1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_wr_contention();
    test_timeout();
    test_abort();
    test_spurious();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
